// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one synchronous imem read per cycle and queues
// PC-tagged words for the decoder. Define IFETCH_PERF_CNT_EN to add fetch_count.
module instr_fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int INSTR_W = 16,
  parameter int OP_W = 4,
  parameter int REG_W = 6,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OP_W-1:0]    out_opcode,
  output logic [REG_W-1:0]   out_rn,
  output logic [REG_W-1:0]   out_rm,
  output logic [ADDR_W-1:0]  out_jaddr,
  output logic               halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  tag;
  logic               inflight;
  logic               issue;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
  logic [INSTR_W-1:0] fifo_instr [DEPTH];

  // Occupancy counts the read in flight so a full FIFO can never be overrun.
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign occ       = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = !halt && !redirect_en && (occ < DEPTH_OCC);
  assign push      = inflight & ~redirect_en;
  assign imem_en   = issue & rst_n;
  assign imem_addr = pc;

  assign out_pc     = out_valid ? fifo_pc[rd_ptr] : '0;
  assign out_instr  = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_opcode = out_instr[INSTR_W-1 -: OP_W];
  assign out_rn     = out_instr[2*REG_W-1 -: REG_W];
  assign out_rm     = out_instr[REG_W-1:0];
  assign out_jaddr  = out_instr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      halted   <= 1'b0;
    end else begin
      halted   <= halt & ~inflight;
      inflight <= issue;
      if (redirect_en) begin
        pc <= redirect_addr;
      end else if (issue) begin
        pc  <= pc + ADDR_W'(1);
        tag <= pc;
      end
    end
  end

  // A redirect flushes the queue; a same-cycle pop needs no pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect_en) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= tag;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random run,
// all checked against a cycle-level behavioural model of the fetch stream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_en;
  logic [11:0] redirect_addr;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_pc;
  logic [15:0] out_instr;
  logic [3:0]  out_opcode;
  logic [5:0]  out_rn;
  logic [5:0]  out_rm;
  logic [11:0] out_jaddr;
  logic        halted;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(12), .INSTR_W(16), .OP_W(4), .REG_W(6), .DEPTH(4), .RESET_PC(12'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .redirect_en(redirect_en),
    .redirect_addr(redirect_addr), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_opcode(out_opcode),
    .out_rn(out_rn), .out_rm(out_rm), .out_jaddr(out_jaddr), .halted(halted)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  function automatic logic [15:0] word_of(input logic [11:0] a);
    return 16'h1000 + 16'(a);
  endfunction

  // Synchronous instruction memory
  always @(posedge clk) if (imem_en) imem_rdata <= word_of(imem_addr);

  // Reference model: program-order PC stream, occupancy bound and halted rule
  logic [11:0] exp_pc, iss_pc;
  logic [15:0] mon_w;
  logic        mon_pop, mon_issue, prev_en, exp_halted;
  int          occ_m, pops_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 12'h000; iss_pc = 12'h000; occ_m = 0; pops_m = 0;
      prev_en = 1'b0; exp_halted = 1'b0;
    end else begin
      mon_pop   = out_valid && out_ready;
      mon_issue = !halt && !redirect_en && ((occ_m - int'(mon_pop)) < 4);
      n_cmp++;
      if (imem_en !== mon_issue) begin
        n_fail++; $display("[TB] FAIL mon_issue: got %b expected %b", imem_en, mon_issue);
      end
      n_cmp++;
      if (halted !== exp_halted) begin
        n_fail++; $display("[TB] FAIL mon_halted: got %b expected %b", halted, exp_halted);
      end
      if (imem_en) begin
        n_cmp++;
        if (imem_addr !== iss_pc) begin
          n_fail++; $display("[TB] FAIL mon_addr: got %h expected %h", imem_addr, iss_pc);
        end
        iss_pc = iss_pc + 12'd1;
      end
      if (mon_pop) begin
        mon_w = word_of(exp_pc);
        n_cmp++;
        if (out_pc !== exp_pc || out_instr !== mon_w) begin
          n_fail++; $display("[TB] FAIL mon_head: got pc %h instr %h expected pc %h instr %h",
                             out_pc, out_instr, exp_pc, mon_w);
        end
        n_cmp++;
        if (out_opcode !== 4'(mon_w / 4096) || out_rn !== 6'((mon_w / 64) % 64) ||
            out_rm !== 6'(mon_w % 64) || out_jaddr !== 12'(mon_w % 4096)) begin
          n_fail++; $display("[TB] FAIL mon_fields: got op %h rn %h rm %h j %h for word %h",
                             out_opcode, out_rn, out_rm, out_jaddr, mon_w);
        end
        exp_pc = exp_pc + 12'd1;
        pops_m++;
      end
      exp_halted = halt && !prev_en;
      prev_en    = imem_en;
      occ_m      = redirect_en ? 0 : occ_m + int'(mon_issue) - int'(mon_pop);
      if (redirect_en) begin
        exp_pc = redirect_addr; iss_pc = redirect_addr;
      end
    end
  end

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0; halt = 1'b0; redirect_en = 1'b0; out_ready = rdy;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b0; redirect_en = 1'b0; redirect_addr = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (imem_en !== 1'b0 || out_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got en %b valid %b halted %b expected 0 0 0",
                         imem_en, out_valid, halted);
    end
    n_cmp++;
    if (out_pc !== 12'h0 || out_instr !== 16'h0 || out_opcode !== 4'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got pc %h instr %h expected 0 0", out_pc, out_instr);
    end
`ifdef IFETCH_PERF_CNT_EN
    n_cmp++;
    if (fetch_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", fetch_count);
    end
`endif
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_en !== 1'b1 || imem_addr !== 12'(c)) begin
        n_fail++; $display("[TB] FAIL stream_addr: got en %b addr %h expected 1 %h", imem_en, imem_addr, 12'(c));
      end
      n_cmp++;
      if (out_valid !== (c >= 2)) begin
        n_fail++; $display("[TB] FAIL stream_valid: got %b expected %b at cycle %0d", out_valid, c >= 2, c);
      end
      if (c >= 2) begin
        n_cmp++;
        if (out_pc !== 12'(c - 2) || out_opcode !== 4'h1 || out_rm !== 6'((c - 2) % 64)) begin
          n_fail++; $display("[TB] FAIL stream_head: got pc %h op %h rm %h expected %h 1 %h",
                             out_pc, out_opcode, out_rm, 12'(c - 2), 6'((c - 2) % 64));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int issues = 0;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_en) issues++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (issues !== 4) begin
      n_fail++; $display("[TB] FAIL bp_issues: got %0d expected 4", issues);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_en !== 1'b1 || imem_addr !== 12'h004 || out_valid !== 1'b1 || out_pc !== 12'h000) begin
      n_fail++; $display("[TB] FAIL bp_resume: got en %b addr %h valid %b pc %h expected 1 004 1 000",
                         imem_en, imem_addr, out_valid, out_pc);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("[TB] FAIL bp_no_bubble: got %b expected 1", out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_redirect();
    logic [11:0] e_addr [5] = '{12'h0A5, 12'h0A6, 12'h0A7, 12'h0A8, 12'h0A9};
    logic        e_vld  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [11:0] e_pc   [5] = '{12'h000, 12'h000, 12'h0A5, 12'h0A6, 12'h0A7};
    do_reset(1'b0);
    repeat (4) begin @(posedge clk); #1; end
    redirect_en = 1'b1; redirect_addr = 12'h0A5;
    @(negedge clk);
    n_cmp++;
    if (imem_en !== 1'b0 || out_valid !== 1'b1 || out_pc !== 12'h000) begin
      n_fail++; $display("[TB] FAIL redir_cycle: got en %b valid %b pc %h expected 0 1 000",
                         imem_en, out_valid, out_pc);
    end
    @(posedge clk); #1;
    redirect_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_en !== 1'b1 || imem_addr !== e_addr[i] || out_valid !== e_vld[i] ||
          (e_vld[i] && out_pc !== e_pc[i])) begin
        n_fail++; $display("[TB] FAIL redir_after: got addr %h valid %b pc %h expected %h %b %h",
                           imem_addr, out_valid, out_pc, e_addr[i], e_vld[i], e_pc[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    logic e_h [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      halt = (k < 5); redirect_en = (k == 2); redirect_addr = 12'h300;
      @(negedge clk);
      n_cmp++;
      if (halted !== e_h[k]) begin
        n_fail++; $display("[TB] FAIL halt_flag: got %b expected %b at step %0d", halted, e_h[k], k);
      end
      n_cmp++;
      if (imem_en !== (k >= 5) || (k == 5 && imem_addr !== 12'h300)) begin
        n_fail++; $display("[TB] FAIL halt_issue: got en %b addr %h at step %0d", imem_en, imem_addr, k);
      end
      if (k >= 3) begin
        n_cmp++;
        if (out_valid !== (k == 7) || (k == 7 && out_pc !== 12'h300)) begin
          n_fail++; $display("[TB] FAIL halt_head: got valid %b pc %h at step %0d", out_valid, out_pc, k);
        end
      end
      @(posedge clk); #1;
    end
    halt = 1'b0; redirect_en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [11:0] e_addr [5] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002};
    redirect_en = 1'b1; redirect_addr = 12'hFFE;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_en !== 1'b1 || imem_addr !== e_addr[j]) begin
        n_fail++; $display("[TB] FAIL wrap_addr: got %h expected %h", imem_addr, e_addr[j]);
      end
      if (j >= 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== e_addr[j-2]) begin
          n_fail++; $display("[TB] FAIL wrap_head: got valid %b pc %h expected 1 %h", out_valid, out_pc, e_addr[j-2]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rstmid_pre: got %b expected 1", out_valid);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_en !== 1'b0 || out_pc !== 12'h0 || halted !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_clear: got valid %b en %b pc %h halted %b expected 0 0 0 0",
                         out_valid, imem_en, out_pc, halted);
    end
`ifdef IFETCH_PERF_CNT_EN
    n_cmp++;
    if (fetch_count !== 32'd0) begin
      n_fail++; $display("[TB] FAIL rstmid_count: got %0d expected 0", fetch_count);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_en !== 1'b1 || imem_addr !== 12'h000) begin
      n_fail++; $display("[TB] FAIL rstmid_restart: got en %b addr %h expected 1 000", imem_en, imem_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int halt_left = 0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom % 4) != 0;
      if (halt_left > 0) begin
        halt = 1'b1; halt_left--;
      end else begin
        halt = 1'b0;
        if ($urandom % 40 == 0) halt_left = $urandom_range(1, 6);
      end
      redirect_en   = ($urandom % 25) == 0;
      redirect_addr = 12'($urandom);
      @(negedge clk);
      if (halt || redirect_en) begin
        n_cmp++;
        if (imem_en !== 1'b0) begin
          n_fail++; $display("[TB] FAIL rand_block: got en %b expected 0", imem_en);
        end
      end
      @(posedge clk); #1;
    end
    halt = 1'b0; redirect_en = 1'b0;
    n_cmp++;
    if (pops_m < 50) begin
      n_fail++; $display("[TB] FAIL rand_progress: got %0d pops expected at least 50", pops_m);
    end
`ifdef IFETCH_PERF_CNT_EN
    n_cmp++;
    if (fetch_count !== 32'(pops_m)) begin
      n_fail++; $display("[TB] FAIL rand_count: got %0d expected %0d", fetch_count, pops_m);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised fetch stage that owns the program counter, issues one read per cycle to a synchronous instruction memory, and buffers returned words in a DEPTH-entry FIFO. The FIFO is tagged with the fetch PC. The block sits between instruction memory and the decoder and presents the split fields (opcode/Rn/Rm/jump address) of the FIFO head under a valid/ready handshake. Halt, jump redirect with flush, and downstream back-pressure are handled internally.

## Interface
- ADDR_W, 12, instruction address / PC width
- INSTR_W, 16, instruction word width; must equal OP_W + 2*REG_W
- OP_W, 4, opcode field width (instr[INSTR_W-1 -: OP_W])
- REG_W, 6, register field width (Rn above Rm)
- DEPTH, 4, FIFO entries; power of two, >= 2
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  level; 1 = stop issuing new fetches
- redirect_en  in  1  one-cycle pulse; jump taken
- redirect_addr  in  ADDR_W  jump target
- imem_en  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address (= current PC)
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_en
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decoder accepts head
- out_pc  out  ADDR_W  PC of head instruction
- out_instr  out  INSTR_W  head instruction word
- out_opcode  out  OP_W  head opcode field
- out_rn  out  REG_W  head Rn field
- out_rm  out  REG_W  head Rm field
- out_jaddr  out  ADDR_W  low ADDR_W bits of head word
- halted  out  1  halt asserted and no read in flight
- fetch_count  out  32  accepted-instruction count (only with IFETCH_PERF_CNT_EN)

## Operation
- Reset values: PC = RESET_PC; FIFO empty; in-flight flag 0; imem_en, out_valid, halted = 0; out_* data = 0; fetch_count = 0.
- pop = out_valid & out_ready.
- issue = !halt & !redirect_en & (count + inflight - pop < DEPTH).
- imem_en = issue (combinational). imem_addr = PC.
- On issue, PC <= PC + 1, modulo 2^ADDR_W; PC 2^ADDR_W-1 wraps to 0. inflight <= 1, tag <= PC.
- The cycle after an issue, {tag, imem_rdata} is pushed into the FIFO unless squashed.
- Push and pop may occur in the same cycle. The issue rule guarantees no overflow; pop on empty cannot occur.
- The out_* fields are driven combinationally from the FIFO head. They are zero when the FIFO is empty.
- redirect_en has highest priority:
  - PC <= redirect_addr.
  - FIFO is flushed (count = 0).
  - Any read in flight is squashed; its data is discarded next cycle.
  - No issue occurs in the redirect cycle.
  - A pop in the same cycle is still honoured; that head was accepted.
- Halt:
  - Stops new issues only.
  - An in-flight read still lands in the FIFO.
  - The FIFO keeps draining to the decoder.
  - halted = halt & !inflight, registered.
- Redirect during halt updates PC and flushes; fetching resumes from the new PC when halt drops.
- rst_n assertion mid-operation returns every register to its reset value immediately. Data in flight is lost.

## Timing
- Issue-to-out_valid latency: 2 cycles. Issue at cycle N, data pushed at the N+1 edge, out_valid high in cycle N+2.
- First imem_en: the first cycle after rst_n deasserts, with imem_addr = RESET_PC.
- Throughput: with DEPTH >= 2 and out_ready held at 1, one instruction per cycle is sustained.
- After redirect in cycle R:
  - First issue at redirect_addr occurs in cycle R+1.
  - out_valid is 0 in R+1 and R+2, and high in R+3.
- Back-pressure: with out_ready = 0, issues stop once count + inflight = DEPTH. Resuming with out_ready = 1 gives an issue in the same cycle as the first pop.
- halted rises 1 cycle after halt rises if nothing is in flight, otherwise 2 cycles after. It falls 1 cycle after halt falls.

## Configuration
- IFETCH_PERF_CNT_EN defined:
  - fetch_count port and 32-bit register exist.
  - The counter increments on every pop and wraps at 2^32.
  - Redirect does not clear it; only reset does.
- IFETCH_PERF_CNT_EN undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset release, imem returns word = 0x1000 + addr, out_ready = 1:
  - imem_addr 0,1,2,… on consecutive cycles.
  - out_valid from cycle 2.
  - out_pc increments by 1 per cycle.
  - out_opcode = 1, out_rm = addr[5:0].
- out_ready = 0 for 10 cycles, then 1 (DEPTH = 4):
  - Exactly 4 issues before the stall.
  - No word lost or duplicated.
  - out_pc sequence is continuous.
- redirect_en with redirect_addr = 0x0A5 while FIFO is full and a read is in flight:
  - The next three out_valid heads carry PC 0x0A5, 0x0A6, 0x0A7.
  - No pre-redirect PC appears after the flush.
- halt high for 5 cycles with redirect_en asserted during the halt:
  - imem_en stays 0.
  - halted = 1.
  - Fetching resumes at the redirect target after halt falls.
- Wrap and reset:
  - PC near 0xFFF runs 0xFFE, 0xFFF, 0x000.
  - rst_n pulsed low mid-stream clears out_valid immediately.
  - With IFETCH_PERF_CNT_EN, fetch_count equals the number of accepted instructions and reads 0 after reset.
